dual_ram: RTL and testbench
===========================

# dual_ram

Simple dual-port synchronous RAM with one write port and one registered read port sharing a single clock. It is a generic storage primitive used wherever a block needs independent read and write addressing in the same cycle, such as small buffers and lookup storage. Contents and the read output clear on reset.

## Interface
- `RAM_WIDTH`, default 8: data word width in bits.
- `RAM_DEPTH`, default 16: number of words; must equal 2**`ADDR_SIZE`.
- `ADDR_SIZE`, default 4: address width in bits.

Ports are listed in positional order; instantiations connect them in this order.
- `clk` input 1: single clock. All state changes on the rising edge, except reset.
- `reset` input 1: asynchronous, active-low reset. Asserted when 0; deasserted when 1.
- `read` input 1: read enable.
- `write` input 1: write enable.
- `rd_addr` input `ADDR_SIZE`: read address.
- `wr_addr` input `ADDR_SIZE`: write address.
- `data_in` input `RAM_WIDTH`: write data.
- `data_out` output `RAM_WIDTH`: registered read data.

## Operation
- Storage: `RAM_DEPTH` words of `RAM_WIDTH` bits each.
- Reset asserted (`reset`=0):
  - Immediately, without waiting for a clock edge, all memory words clear to 0 and `data_out` clears to 0.
  - Reset overrides `read` and `write`.
  - Reset asserted mid-operation discards any write in progress.
- Write: on a `clk` rising edge with `reset`=1 and `write`=1, `mem[wr_addr]` <= `data_in`.
- Read: on a `clk` rising edge with `reset`=1 and `read`=1, `data_out` <= `mem[rd_addr]`.
- Output hold: when `read`=0, `data_out` holds its last value.
- Independent ports: read and write may both be active in the same cycle at any pair of addresses.
- Read-during-write to the same address is read-first: `data_out` receives the pre-write contents, and the new data is visible on the next read.
- Address range: addresses cover 0 to `RAM_DEPTH`-1 exactly, so no out-of-range case exists.

## Timing
- Write latency: the new data is readable by a read issued on the next rising edge after the write edge.
- Read latency: one cycle. `data_out` is valid after the rising edge on which `read`=1 was sampled.
- No combinational path exists from any input to `data_out`.
- No handshake and no back-pressure: one read and one write are accepted every cycle.
- Reset release is synchronous-safe: the first edge with `reset`=1 may perform a write and/or a read.

## Structure
- Width and depth parameters stay local to the module. No shared package is required.
- Keep the `RAM_DEPTH` == 2**`ADDR_SIZE` relation checked by an elaboration-time assertion.
- Natural sub-module: `ram_array`, holding the storage, the asynchronous clear and the write port.
- The top level owns the read-enable register for `data_out` and the read-first multiplexing.

## Test plan
- Reset: drive `reset`=0 for 2 cycles, then release -> `data_out`=0x00, and reading addresses 0..15 with `read`=1 returns 0x00 each time.
- Write then read: write 0xA5 @ 3 and 0x3C @ 15, then read 3 and then 15 -> `data_out` is 0xA5 one cycle after the first read and 0x3C one cycle after the second.
- Simultaneous different addresses: in one cycle write 0x77 @ 5 while reading @ 3 (holding 0xA5) -> `data_out`=0xA5. A following read @ 5 gives 0x77.
- Read-during-write to the same address: with `mem[7]`=0x11, write 0x22 @ 7 while reading @ 7 -> `data_out`=0x11. The next read @ 7 gives 0x22.
- Hold and overwrite:
  - Read @ 3 yields 0xA5, then drop `read` for 3 cycles while writing 0xFF @ 3 -> `data_out` stays 0xA5.
  - A re-read @ 3 then gives 0xFF.
- Asynchronous reset mid-operation: assert `reset`=0 between clock edges while `write`=1 -> `data_out` goes to 0 before the next edge, and all addresses subsequently read 0x00.

Source files
------------

// File: rtl/dual_ram_pkg.sv
// Shared helpers for the dual_ram storage primitive.
package dual_ram_pkg;

  // Number of words an address of the given width can reach.
  function automatic int unsigned depth_for(input int unsigned addr_size);
    return 32'd1 << addr_size;
  endfunction

endpackage

// File: rtl/dual_ram_array.sv
// Storage array for dual_ram: asynchronous clear, synchronous write port and
// an unregistered view of the word at the read address.
module dual_ram_array #(
  parameter int unsigned RAM_WIDTH = 8,
  parameter int unsigned RAM_DEPTH = 16,
  parameter int unsigned ADDR_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [RAM_WIDTH-1:0] data_in,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [RAM_WIDTH-1:0] rd_word
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  // Clear every word on reset; otherwise commit the write on the rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(RAM_DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (write) begin
      mem[wr_addr] <= data_in;
    end
  end

  // Contents as they stand before this edge's write lands.
  assign rd_word = mem[rd_addr];

endmodule

// File: rtl/dual_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module dual_ram
  import dual_ram_pkg::*;
#(
  parameter int unsigned RAM_WIDTH = 8,
  parameter int unsigned RAM_DEPTH = 16,
  parameter int unsigned ADDR_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read,
  input  logic                 write,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [RAM_WIDTH-1:0] data_in,
  output logic [RAM_WIDTH-1:0] data_out
);

  // The address must reach every word and nothing beyond.
  if (RAM_DEPTH != depth_for(ADDR_SIZE)) begin : gen_depth_check
    $error("dual_ram: RAM_DEPTH must equal 2**ADDR_SIZE");
  end

  logic [RAM_WIDTH-1:0] rd_word;
  logic [RAM_WIDTH-1:0] data_q;

  dual_ram_array #(
    .RAM_WIDTH (RAM_WIDTH),
    .RAM_DEPTH (RAM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_ram_array (
    .clk     (clk),
    .reset   (reset),
    .write   (write),
    .wr_addr (wr_addr),
    .data_in (data_in),
    .rd_addr (rd_addr),
    .rd_word (rd_word)
  );

  // Capture read data when enabled, hold otherwise. rd_word is sampled on the
  // same edge that commits a write, so a same-address collision is read-first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else if (read) begin
      data_q <= rd_word;
    end
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_dual_ram.sv
// Self-checking bench for dual_ram using a reference model and result queue.
module tb_dual_ram;

  logic       clk;
  logic       reset;
  logic       read;
  logic       write;
  logic [3:0] rd_addr;
  logic [3:0] wr_addr;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int n_checks;
  int n_errors;

  logic [7:0] exp_mem [16];
  logic [7:0] model_out;
  logic [7:0] exp_q [$];

  dual_ram #(
    .RAM_WIDTH (8),
    .RAM_DEPTH (16),
    .ADDR_SIZE (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .read     (read),
    .write    (write),
    .rd_addr  (rd_addr),
    .wr_addr  (wr_addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
    model_out = 8'h00;
  endtask

  // Drive one cycle, push the model's expected output, then compare after the edge.
  task automatic do_cycle(input logic rd, input logic wr, input logic [3:0] ra,
                          input logic [3:0] wa, input logic [7:0] din, input string tag);
    read    = rd;
    write   = wr;
    rd_addr = ra;
    wr_addr = wa;
    data_in = din;
    if (rd) model_out = exp_mem[ra];
    if (wr) exp_mem[wa] = din;
    exp_q.push_back(model_out);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      check_eq(tag, data_out, exp_q.pop_front());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    read     = 1'b0;
    write    = 1'b0;
    rd_addr  = '0;
    wr_addr  = '0;
    data_in  = '0;
    model_clear();

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out", data_out, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) do_cycle(1'b1, 1'b0, 4'(i), 4'd0, 8'h00, "rst_rd");

    // Write then read.
    do_cycle(1'b0, 1'b1, 4'd0, 4'd3, 8'hA5, "wr3_hold");
    do_cycle(1'b0, 1'b1, 4'd0, 4'd15, 8'h3C, "wr15_hold");
    do_cycle(1'b1, 1'b0, 4'd3, 4'd0, 8'h00, "rd3");
    do_cycle(1'b1, 1'b0, 4'd15, 4'd0, 8'h00, "rd15");

    // Simultaneous ports, different addresses.
    do_cycle(1'b1, 1'b1, 4'd3, 4'd5, 8'h77, "sim_rd3_wr5");
    do_cycle(1'b1, 1'b0, 4'd5, 4'd0, 8'h00, "rd5");

    // Read-during-write, same address: read-first.
    do_cycle(1'b0, 1'b1, 4'd0, 4'd7, 8'h11, "wr7");
    do_cycle(1'b1, 1'b1, 4'd7, 4'd7, 8'h22, "rdw7_old");
    do_cycle(1'b1, 1'b0, 4'd7, 4'd0, 8'h00, "rd7_new");

    // Random traffic on both ports.
    for (int i = 0; i < 40; i++) begin
      do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 8'($urandom), "rand");
    end

    // Hold while overwriting the read word.
    do_cycle(1'b0, 1'b1, 4'd0, 4'd3, 8'hA5, "rewr3");
    do_cycle(1'b1, 1'b0, 4'd3, 4'd0, 8'h00, "rd3_again");
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b1, 4'd0, 4'd3, 8'hFF, "hold");
    do_cycle(1'b1, 1'b0, 4'd3, 4'd0, 8'h00, "rd3_ff");

    // Asynchronous reset between edges while a write is pending.
    read    = 1'b0;
    write   = 1'b1;
    wr_addr = 4'd9;
    data_in = 8'h55;
    #3;
    reset = 1'b0;
    #1;
    check_eq("async_clr", data_out, 8'h00);
    @(posedge clk);
    #1;
    check_eq("async_hold", data_out, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    write = 1'b0;
    model_clear();
    for (int i = 0; i < 16; i++) do_cycle(1'b1, 1'b0, 4'(i), 4'd0, 8'h00, "post_rst_rd");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
